// File: rtl/tag_buffer.sv
// tag_buffer: bitmap-based physical-tag free list for the rename stage.
// specUsed tracks speculative allocation, comUsed tracks committed mappings.
// A mispredict restores specUsed from comUsed (with same-cycle commits applied).
//
// Issue handshake: OUT_ready is the ready side and each IN_issueValid[i] is a
// per-slot valid. A slot's tag is consumed at the edge where its valid is high,
// OUT_ready is high and IN_mispred is low. Raising a valid while OUT_ready is
// low is illegal, and nothing is allocated. OUT_ready does not depend on the
// valids, so the renamer may look at it before it decides to request.
module tag_buffer #(
  parameter int NUM_ISSUE  = 4,
  parameter int NUM_COMMIT = 4,
  parameter int TAG_SIZE   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN_mispred,
  input  logic                IN_mispredFlush,
  input  logic                IN_issueValid     [NUM_ISSUE],
  output logic [TAG_SIZE-1:0] OUT_issueTags     [NUM_ISSUE],
  output logic                OUT_ready,
  input  logic                IN_commitValid    [NUM_COMMIT],
  input  logic [TAG_SIZE-1:0] IN_commitNewTags  [NUM_COMMIT],
  input  logic [TAG_SIZE-1:0] IN_commitPrevTags [NUM_COMMIT],
  output logic [TAG_SIZE-1:0] OUT_freeCnt
);

  localparam int IDX_W    = TAG_SIZE - 1;
  localparam int NUM_TAGS = 1 << IDX_W;

  logic [NUM_TAGS-1:0] spec_used, com_used;
  logic [NUM_TAGS-1:0] spec_next, com_next;
  logic [NUM_TAGS-1:0] alloc_mask, free_mask, taken;
  logic [TAG_SIZE-1:0] free_cnt, free_cnt_next;
  logic                alloc_en, req_any, found, bad_free;

  assign OUT_ready   = (free_cnt >= TAG_SIZE'(NUM_ISSUE));
  assign OUT_freeCnt = free_cnt;
  assign alloc_en    = !IN_mispred && OUT_ready;

  // Hand the lowest free tags to valid slots in slot order; invalid slots
  // show the next candidate but do not consume it.
  always_comb begin
    taken      = spec_used;
    alloc_mask = '0;
    found      = 1'b0;
    req_any    = 1'b0;
    for (int s = 0; s < NUM_ISSUE; s++) begin
      OUT_issueTags[s] = '0;
      found            = 1'b0;
      req_any          = req_any | IN_issueValid[s];
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (!found && !taken[t]) begin
          found            = 1'b1;
          OUT_issueTags[s] = TAG_SIZE'(t);
          if (IN_issueValid[s]) begin
            taken[t]      = 1'b1;
            alloc_mask[t] = 1'b1;
          end
        end
      end
    end
  end

  // Next bitmaps: allocation first, then commits (frees win over allocation),
  // then mispredict rollback onto the updated committed map.
  always_comb begin
    com_next  = com_used;
    spec_next = spec_used;
    free_mask = '0;
    bad_free  = 1'b0;
    if (alloc_en) spec_next = spec_next | alloc_mask;
    for (int c = 0; c < NUM_COMMIT; c++) begin
      if (IN_commitValid[c]) begin
        if (!IN_mispredFlush) begin
          if (!IN_commitNewTags[c][IDX_W])
            com_next[IN_commitNewTags[c][IDX_W-1:0]] = 1'b1;
          if (!IN_commitPrevTags[c][IDX_W]) begin
            if (!com_next[IN_commitPrevTags[c][IDX_W-1:0]]) bad_free = 1'b1;
            com_next[IN_commitPrevTags[c][IDX_W-1:0]]  = 1'b0;
            spec_next[IN_commitPrevTags[c][IDX_W-1:0]] = 1'b0;
            free_mask[IN_commitPrevTags[c][IDX_W-1:0]] = 1'b1;
          end
        end else if (!IN_mispred && !IN_commitNewTags[c][IDX_W]) begin
          // Replayed mapping is in flight again.
          spec_next[IN_commitNewTags[c][IDX_W-1:0]] = 1'b1;
        end
      end
    end
    if (IN_mispred) spec_next = com_next;
  end

  // Free count is the popcount of the next ~specUsed.
  always_comb begin
    free_cnt_next = '0;
    for (int t = 0; t < NUM_TAGS; t++)
      if (!spec_next[t]) free_cnt_next = free_cnt_next + TAG_SIZE'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_used <= '0;
      com_used  <= '0;
      free_cnt  <= TAG_SIZE'(NUM_TAGS);
    end else begin
      spec_used <= spec_next;
      com_used  <= com_next;
      free_cnt  <= free_cnt_next;
    end
  end

  // Protocol checks: request while not ready, freeing an uncommitted tag,
  // and freeing a tag that is being allocated in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_req_not_ready: assert (!(req_any && !OUT_ready && !IN_mispred));
      a_bad_free:      assert (!bad_free);
      a_free_alloc:    assert (!(alloc_en && |(alloc_mask & free_mask)));
    end
  end

endmodule

// File: tb/tb_tag_buffer.sv
// Testbench for tag_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against a free-list reference model.
module tb_tag_buffer;

  localparam int NI = 4;
  localparam int NC = 4;
  localparam int TS = 7;
  localparam int NT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mispred, flush;
  logic          issue_valid [NI];
  logic [TS-1:0] issue_tags  [NI];
  logic          ready;
  logic          commit_valid [NC];
  logic [TS-1:0] commit_new   [NC];
  logic [TS-1:0] commit_prev  [NC];
  logic [TS-1:0] free_cnt;

  int checks = 0;
  int errors = 0;

  // scoreboard of expected tags for the current cycle
  logic [TS-1:0] exp_q[$];

  // reference model: which tags are speculatively / committed in use
  bit m_spec [NT];
  bit m_com  [NT];

  tag_buffer #(.NUM_ISSUE(NI), .NUM_COMMIT(NC), .TAG_SIZE(TS)) dut (
    .clk               (clk),
    .rst               (rst),
    .IN_mispred        (mispred),
    .IN_mispredFlush   (flush),
    .IN_issueValid     (issue_valid),
    .OUT_issueTags     (issue_tags),
    .OUT_ready         (ready),
    .IN_commitValid    (commit_valid),
    .IN_commitNewTags  (commit_new),
    .IN_commitPrevTags (commit_prev),
    .OUT_freeCnt       (free_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_spec[t] = 1'b0;
      m_com[t]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    mispred = 1'b0;
    flush   = 1'b0;
    for (int i = 0; i < NI; i++) issue_valid[i] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      commit_valid[i] = 1'b0;
      commit_new[i]   = '0;
      commit_prev[i]  = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, check against the model at the falling edge, return the
  // observed outputs, then advance the model at the rising edge.
  task automatic cycle(input logic [3:0] v, input logic mp, input logic fl,
                       input logic [3:0] cv, input logic [3:0][6:0] cn,
                       input logic [3:0][6:0] cp,
                       output logic [3:0][6:0] obs_tags, output int obs_cnt,
                       output logic obs_rdy);
    int free_q[$];
    int alloc_t[$];
    int exp_cnt;
    bit exp_rdy;
    mispred = mp;
    flush   = fl;
    for (int i = 0; i < NI; i++) issue_valid[i] = v[i];
    for (int i = 0; i < NC; i++) begin
      commit_valid[i] = cv[i];
      commit_new[i]   = cn[i];
      commit_prev[i]  = cp[i];
    end
    @(negedge clk);
    for (int t = 0; t < NT; t++) if (!m_spec[t]) free_q.push_back(t);
    exp_cnt = free_q.size();
    exp_rdy = (exp_cnt >= NI);
    for (int s = 0; s < NI; s++) obs_tags[s] = issue_tags[s];
    obs_cnt = int'(free_cnt);
    obs_rdy = ready;
    chk("free_cnt", int'(free_cnt), exp_cnt);
    chk("ready", int'(ready), int'(exp_rdy));
    for (int s = 0; s < NI; s++)
      if (v[s] && free_q.size() > 0) begin
        alloc_t.push_back(free_q[0]);
        exp_q.push_back(TS'(free_q.pop_front()));
      end
    for (int s = 0; s < NI; s++)
      if (v[s] && exp_q.size() > 0) chk("issue_tag", int'(issue_tags[s]), int'(exp_q.pop_front()));
    @(posedge clk);
    if (!mp && exp_rdy) foreach (alloc_t[k]) m_spec[alloc_t[k]] = 1'b1;
    for (int c = 0; c < NC; c++) begin
      if (cv[c]) begin
        if (!fl) begin
          if (cn[c] < NT) m_com[cn[c]] = 1'b1;
          if (cp[c] < NT) begin
            m_com[cp[c]]  = 1'b0;
            m_spec[cp[c]] = 1'b0;
          end
        end else if (!mp && cn[c] < NT) begin
          m_spec[cn[c]] = 1'b1;
        end
      end
    end
    if (mp) for (int t = 0; t < NT; t++) m_spec[t] = m_com[t];
    #1;
  endtask

  // One randomized but legal cycle.
  task automatic rand_cycle();
    int inflight[$];
    int comq[$];
    int nfree;
    int idx;
    logic [3:0] v, cv;
    logic [3:0][6:0] cn, cp, ot;
    logic mp, fl, orr;
    int oc, r;
    nfree = 0;
    for (int t = 0; t < NT; t++) begin
      if (!m_spec[t]) nfree++;
      if (m_spec[t] && !m_com[t]) inflight.push_back(t);
      if (m_com[t]) comq.push_back(t);
    end
    r  = $urandom_range(0, 15);
    mp = (r == 0);
    fl = (r == 1);
    v  = (nfree >= NI) ? 4'($urandom_range(0, 15)) : 4'b0000;
    cv = '0;
    cn = '0;
    cp = '0;
    for (int c = 0; c < NC; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        cv[c] = 1'b1;
        if (fl) begin
          cn[c] = 7'($urandom_range(0, 127));
          cp[c] = 7'($urandom_range(0, 127));
        end else begin
          if (inflight.size() > 0) begin
            idx   = $urandom_range(0, inflight.size() - 1);
            cn[c] = 7'(inflight[idx]);
            inflight.delete(idx);
          end else begin
            cn[c] = 7'(64 + $urandom_range(0, 63));
          end
          if (comq.size() > 0 && $urandom_range(0, 1) == 1) begin
            idx   = $urandom_range(0, comq.size() - 1);
            cp[c] = 7'(comq[idx]);
            comq.delete(idx);
          end else begin
            cp[c] = 7'(64 + $urandom_range(0, 63));
          end
        end
      end
    end
    cycle(v, mp, fl, cv, cn, cp, ot, oc, orr);
  endtask

  typedef struct {
    logic [3:0] valid;
    int         tags [4];
    int         cnt;
    logic       rdy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [3:0][6:0] z;
    logic [3:0][6:0] cn, cp, ot;
    int oc;
    logic orr;
    z = '0;

    tbl[0] = '{4'b1111, '{0, 1, 2, 3},   64, 1'b1};
    tbl[1] = '{4'b1111, '{4, 5, 6, 7},   60, 1'b1};
    tbl[2] = '{4'b1111, '{8, 9, 10, 11}, 56, 1'b1};
    tbl[3] = '{4'b1010, '{0, 12, 0, 13}, 52, 1'b1};
    tbl[4] = '{4'b0000, '{0, 0, 0, 0},   50, 1'b1};
    tbl[5] = '{4'b0101, '{14, 0, 15, 0}, 50, 1'b1};
    tbl[6] = '{4'b0000, '{0, 0, 0, 0},   48, 1'b1};

    // directed vector table from reset
    do_reset();
    foreach (tbl[k]) begin
      cycle(tbl[k].valid, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
      chk("tbl_cnt", oc, tbl[k].cnt);
      chk("tbl_ready", int'(orr), int'(tbl[k].rdy));
      for (int s = 0; s < NI; s++)
        if (tbl[k].valid[s]) chk("tbl_tag", int'(ot[s]), tbl[k].tags[s]);
    end

    // near full: 60 allocated, then one more, then a commit frees tag 2
    do_reset();
    for (int i = 0; i < 15; i++) cycle(4'b1111, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    cycle(4'b0001, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    chk("nf_cnt4", oc, 4);
    chk("nf_ready4", int'(orr), 1);
    chk("nf_tag60", int'(ot[0]), 60);
    cn = z; cp = z; cn[0] = 7'd2; cp[0] = 7'd64;
    cycle(4'b0000, 1'b0, 1'b0, 4'b0001, cn, cp, ot, oc, orr);
    chk("nf_cnt3", oc, 3);
    chk("nf_ready3", int'(orr), 0);
    cn[0] = 7'd5; cp[0] = 7'd2;
    cycle(4'b0000, 1'b0, 1'b0, 4'b0001, cn, cp, ot, oc, orr);
    chk("special_prev_cnt", oc, 3);
    cycle(4'b0001, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    chk("nf_freed_cnt", oc, 4);
    chk("nf_freed_ready", int'(orr), 1);
    chk("nf_freed_tag", int'(ot[0]), 2);

    // mispredict rollback then flush replay
    do_reset();
    cycle(4'b1111, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    cycle(4'b1111, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    for (int c = 0; c < NC; c++) begin
      cn[c] = 7'(c);
      cp[c] = 7'(64 + c);
    end
    cycle(4'b0000, 1'b0, 1'b0, 4'b1111, cn, cp, ot, oc, orr);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0000, z, z, ot, oc, orr);
    cycle(4'b1111, 1'b1, 1'b0, 4'b0000, z, z, ot, oc, orr);
    chk("mp_cnt", oc, 60);
    for (int s = 0; s < NI; s++) chk("mp_tag", int'(ot[s]), 4 + s);
    cn = z; cp = z;
    cn[0] = 7'd4; cn[1] = 7'd5; cp[0] = 7'd9; cp[1] = 7'd9;
    cycle(4'b0000, 1'b0, 1'b1, 4'b0011, cn, cp, ot, oc, orr);
    cycle(4'b1111, 1'b0, 1'b0, 4'b0000, z, z, ot, oc, orr);
    chk("flush_cnt", oc, 58);
    for (int s = 0; s < NI; s++) chk("flush_tag", int'(ot[s]), 6 + s);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
